// File: rtl/color_track_pkg.sv
// Shared definitions for the colour trackers: RGB565 field positions,
// tracker frame states and the default overlay colour.
package color_track_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PUBLISH = 2'd2
  } track_state_e;

  localparam logic [15:0] DEFAULT_BOX_COLOR = 16'hF800;

endpackage

// File: rtl/rgb565_window_cmp.sv
// Combinational inclusive window compare on the three RGB565 channels.
// A channel whose min exceeds its max can never match.
module rgb565_window_cmp
  import color_track_pkg::*;
(
  input  logic [15:0] pixel,
  input  logic [4:0]  r_min,
  input  logic [4:0]  r_max,
  input  logic [5:0]  g_min,
  input  logic [5:0]  g_max,
  input  logic [4:0]  b_min,
  input  logic [4:0]  b_max,
  output logic        match
);

  logic [4:0] r_s;
  logic [5:0] g_s;
  logic [4:0] b_s;

  assign r_s = pixel[R_MSB:R_LSB];
  assign g_s = pixel[G_MSB:G_LSB];
  assign b_s = pixel[B_MSB:B_LSB];

  assign match = (r_s >= r_min) && (r_s <= r_max) &&
                 (g_s >= g_min) && (g_s <= g_max) &&
                 (b_s >= b_min) && (b_s <= b_max);

endmodule

// File: rtl/color_bbox_tracker.sv
// Per-frame bounding box and hit count of pixels inside an RGB565 colour window.
// Define COLOR_BBOX_OVERLAY_EN to draw the previous valid box onto out_data.
module color_bbox_tracker
  import color_track_pkg::*;
#(
  parameter int          COORD_W    = 12,
  parameter int          CNT_W      = 20,
  parameter int          MIN_PIXELS = 64,
  parameter logic [15:0] BOX_COLOR  = DEFAULT_BOX_COLOR
) (
  input  logic               cmos_pclk,
  input  logic               rst_n,
  input  logic               in_vsync,
  input  logic               in_href,
  input  logic [15:0]        in_data,
  input  logic               in_clken,
  input  logic [4:0]         r_min,
  input  logic [4:0]         r_max,
  input  logic [5:0]         g_min,
  input  logic [5:0]         g_max,
  input  logic [4:0]         b_min,
  input  logic [4:0]         b_max,
  output logic               out_vsync,
  output logic               out_href,
  output logic [15:0]        out_data,
  output logic               out_clken,
  output logic               pixel_hit,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic               bbox_valid,
  output logic [CNT_W-1:0]   hit_count,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONES = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONES   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_PIXELS);

  logic               vsync_d_r;
  logic               href_d_r;
  logic               vs_rise_s;
  logic               vs_fall_s;
  logic               hs_fall_s;
  logic               win_match_s;
  logic               hit_s;
  logic [15:0]        pix_out_s;
  logic [COORD_W-1:0] x_cnt_r;
  logic [COORD_W-1:0] y_cnt_r;
  logic [COORD_W-1:0] acc_x_min_r;
  logic [COORD_W-1:0] acc_x_max_r;
  logic [COORD_W-1:0] acc_y_min_r;
  logic [COORD_W-1:0] acc_y_max_r;
  logic [CNT_W-1:0]   acc_cnt_r;
  track_state_e       state_r;

  assign vs_rise_s = in_vsync & ~vsync_d_r;
  assign vs_fall_s = ~in_vsync & vsync_d_r;
  assign hs_fall_s = ~in_href & href_d_r;
  assign hit_s     = in_clken & in_href & win_match_s;

  rgb565_window_cmp u_win (
    .pixel (in_data),
    .r_min (r_min),
    .r_max (r_max),
    .g_min (g_min),
    .g_max (g_max),
    .b_min (b_min),
    .b_max (b_max),
    .match (win_match_s)
  );

`ifdef COLOR_BBOX_OVERLAY_EN
  logic on_col_s;
  logic on_row_s;
  logic in_xspan_s;
  logic in_yspan_s;
  logic border_s;

  assign on_col_s   = (x_cnt_r == bbox_x_min) || (x_cnt_r == bbox_x_max);
  assign on_row_s   = (y_cnt_r == bbox_y_min) || (y_cnt_r == bbox_y_max);
  assign in_xspan_s = (x_cnt_r >= bbox_x_min) && (x_cnt_r <= bbox_x_max);
  assign in_yspan_s = (y_cnt_r >= bbox_y_min) && (y_cnt_r <= bbox_y_max);
  assign border_s   = bbox_valid & in_clken & in_href &
                      ((on_col_s & in_yspan_s) | (on_row_s & in_xspan_s));
  assign pix_out_s  = border_s ? BOX_COLOR : in_data;
`else
  logic [15:0] unused_box_color_s;

  assign unused_box_color_s = BOX_COLOR;
  assign pix_out_s          = in_data;
`endif

  // Pass-through pipeline, edge history and pixel coordinates.
  // vsync history resets high so a frame already in flight at reset release
  // is not mistaken for a fresh frame start.
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b1;
      href_d_r  <= 1'b0;
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
      out_data  <= 16'h0000;
      out_clken <= 1'b0;
      pixel_hit <= 1'b0;
      x_cnt_r   <= COORD_ZERO;
      y_cnt_r   <= COORD_ZERO;
    end else begin
      vsync_d_r <= in_vsync;
      href_d_r  <= in_href;
      out_vsync <= in_vsync;
      out_href  <= in_href;
      out_data  <= pix_out_s;
      out_clken <= in_clken;
      pixel_hit <= hit_s;
      if (!in_href) begin
        x_cnt_r <= COORD_ZERO;
      end else if (in_clken) begin
        x_cnt_r <= x_cnt_r + COORD_ONE;
      end else begin
        x_cnt_r <= x_cnt_r;
      end
      if (vs_rise_s) begin
        y_cnt_r <= COORD_ZERO;
      end else if (hs_fall_s) begin
        y_cnt_r <= y_cnt_r + COORD_ONE;
      end else begin
        y_cnt_r <= y_cnt_r;
      end
    end
  end

  // Box and hit accumulators; a frame start wins over a coincident hit.
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n || vs_rise_s) begin
      acc_x_min_r <= COORD_ONES;
      acc_x_max_r <= COORD_ZERO;
      acc_y_min_r <= COORD_ONES;
      acc_y_max_r <= COORD_ZERO;
      acc_cnt_r   <= CNT_ZERO;
    end else if (hit_s) begin
      acc_x_min_r <= (x_cnt_r < acc_x_min_r) ? x_cnt_r : acc_x_min_r;
      acc_x_max_r <= (x_cnt_r > acc_x_max_r) ? x_cnt_r : acc_x_max_r;
      acc_y_min_r <= (y_cnt_r < acc_y_min_r) ? y_cnt_r : acc_y_min_r;
      acc_y_max_r <= (y_cnt_r > acc_y_max_r) ? y_cnt_r : acc_y_max_r;
      acc_cnt_r   <= (acc_cnt_r == CNT_ONES) ? acc_cnt_r : acc_cnt_r + CNT_ONE;
    end else begin
      acc_x_min_r <= acc_x_min_r;
      acc_x_max_r <= acc_x_max_r;
      acc_y_min_r <= acc_y_min_r;
      acc_y_max_r <= acc_y_max_r;
      acc_cnt_r   <= acc_cnt_r;
    end
  end

  // Frame sequencing and published results, which hold between frames.
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bbox_x_min <= COORD_ZERO;
      bbox_x_max <= COORD_ZERO;
      bbox_y_min <= COORD_ZERO;
      bbox_y_max <= COORD_ZERO;
      bbox_valid <= 1'b0;
      hit_count  <= CNT_ZERO;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= vs_rise_s ? ARMED : IDLE;
        end
        ARMED: begin
          state_r <= vs_fall_s ? PUBLISH : ARMED;
        end
        PUBLISH: begin
          // a one-cycle vsync gap must still arm the following frame
          state_r    <= vs_rise_s ? ARMED : IDLE;
          bbox_x_min <= acc_x_min_r;
          bbox_x_max <= acc_x_max_r;
          bbox_y_min <= acc_y_min_r;
          bbox_y_max <= acc_y_max_r;
          bbox_valid <= (acc_cnt_r >= MIN_CNT);
          hit_count  <= acc_cnt_r;
          frame_done <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Directed-frame bench for color_bbox_tracker with a frame-level reference model.
// Overlay expectations are enabled by COLOR_BBOX_OVERLAY_EN.
module tb_color_bbox_tracker;

  localparam int MIN_P = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vsync, in_href, in_clken;
  logic [15:0] in_data;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic        out_vsync, out_href, out_clken, pixel_hit, bbox_valid, frame_done;
  logic [15:0] out_data;
  logic [11:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [19:0] hit_count;

  color_bbox_tracker #(.MIN_PIXELS(MIN_P)) dut (
    .cmos_pclk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
    .in_data(in_data), .in_clken(in_clken),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data),
    .out_clken(out_clken), .pixel_hit(pixel_hit),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .bbox_valid(bbox_valid), .hit_count(hit_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int drv_x = 0, drv_y = 0;
  logic [15:0] frame_pix [0:3][0:7];
  logic [15:0] obs       [0:3][0:7];

  // model state
  logic        s_rst, s_vsync, s_href, s_clken;
  logic [15:0] s_data;
  int          s_x, s_y;
  int          hx_q[$], hy_q[$];
  bit          armed, vs_prev, pend, e_hit, e_done, rise, fall;
  logic [15:0] e_data;
  int          m_x0, m_x1, m_y0, m_y1, m_cnt;  bit m_valid;
  int          p_x0, p_x1, p_y0, p_y1, p_cnt;  bit p_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit win_ok(input logic [15:0] d);
    return d[15:11] >= r_min && d[15:11] <= r_max &&
           d[10:5]  >= g_min && d[10:5]  <= g_max &&
           d[4:0]   >= b_min && d[4:0]   <= b_max;
  endfunction

`ifdef COLOR_BBOX_OVERLAY_EN
  function automatic bit on_border(input int x, input int y);
    return ((x == m_x0 || x == m_x1) && y >= m_y0 && y <= m_y1) ||
           ((y == m_y0 || y == m_y1) && x >= m_x0 && x <= m_x1);
  endfunction
`endif

  always @(posedge clk) begin
    s_rst = rst_n; s_vsync = in_vsync; s_href = in_href;
    s_clken = in_clken; s_data = in_data; s_x = drv_x; s_y = drv_y;
  end

  // One compare process: per-pixel outputs every cycle, frame results every cycle.
  always @(negedge clk) begin
    if (!s_rst) begin
      chk("rst_pixel_hit", 32'(pixel_hit), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sync", 32'({out_vsync, out_href, out_clken}), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_hit_count", 32'(hit_count), 32'd0);
      chk("rst_bbox_valid", 32'(bbox_valid), 32'd0);
      chk("rst_bbox", 32'({bbox_x_min, bbox_x_max}), 32'd0);
      chk("rst_bbox_y", 32'({bbox_y_min, bbox_y_max}), 32'd0);
      hx_q.delete(); hy_q.delete();
      armed = 1'b0; vs_prev = 1'b1; pend = 1'b0;
      m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_cnt = 0; m_valid = 1'b0;
    end else begin
      e_hit  = s_clken && s_href && win_ok(s_data);
      e_data = s_data;
`ifdef COLOR_BBOX_OVERLAY_EN
      if (m_valid && s_clken && s_href && on_border(s_x, s_y)) e_data = 16'hF800;
`endif
      chk("pixel_hit", 32'(pixel_hit), 32'(e_hit));
      chk("out_data", 32'(out_data), 32'(e_data));
      chk("out_vsync", 32'(out_vsync), 32'(s_vsync));
      chk("out_href", 32'(out_href), 32'(s_href));
      chk("out_clken", 32'(out_clken), 32'(s_clken));
      e_done = pend;
      if (pend) begin
        m_x0 = p_x0; m_x1 = p_x1; m_y0 = p_y0; m_y1 = p_y1;
        m_cnt = p_cnt; m_valid = p_valid; pend = 1'b0;
      end
      chk("frame_done", 32'(frame_done), 32'(e_done));
      if (frame_done) done_cnt++;
      chk("hit_count", 32'(hit_count), 32'(m_cnt));
      chk("bbox_valid", 32'(bbox_valid), 32'(m_valid));
      if (m_valid) begin
        chk("bbox_x_min", 32'(bbox_x_min), 32'(m_x0));
        chk("bbox_x_max", 32'(bbox_x_max), 32'(m_x1));
        chk("bbox_y_min", 32'(bbox_y_min), 32'(m_y0));
        chk("bbox_y_max", 32'(bbox_y_max), 32'(m_y1));
      end
      if (s_clken && s_href && s_y < 4 && s_x < 8) obs[s_y][s_x] = out_data;
      rise = s_vsync && !vs_prev;
      fall = !s_vsync && vs_prev;
      if (rise) begin
        armed = 1'b1; hx_q.delete(); hy_q.delete();
      end else if (e_hit) begin
        hx_q.push_back(s_x); hy_q.push_back(s_y);
      end
      if (fall && armed) begin
        p_x0 = 4095; p_x1 = 0; p_y0 = 4095; p_y1 = 0;
        foreach (hx_q[i]) begin
          if (hx_q[i] < p_x0) p_x0 = hx_q[i];
          if (hx_q[i] > p_x1) p_x1 = hx_q[i];
          if (hy_q[i] < p_y0) p_y0 = hy_q[i];
          if (hy_q[i] > p_y1) p_y1 = hy_q[i];
        end
        p_cnt = hx_q.size(); p_valid = (p_cnt >= MIN_P);
        pend = 1'b1; armed = 1'b0;
      end
      vs_prev = s_vsync;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_frame();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) frame_pix[y][x] = 16'h07E0;
  endtask

  task automatic drive_line(input int l, input bit fall_last);
    for (int p = 0; p < 8; p++) begin
      in_href = 1'b1; in_clken = 1'b1; in_data = frame_pix[l][p];
      drv_x = p; drv_y = l;
      if (fall_last && p == 7) in_vsync = 1'b0;
      step(1);
      in_clken = 1'b0; in_data = 16'h0000; step(1);
    end
    in_href = 1'b0; step(2);
  endtask

  task automatic drive_frame(input bit fall_last);
    in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0; step(2);
    in_vsync = 1'b1; step(2);
    for (int l = 0; l < 4; l++) drive_line(l, fall_last && l == 3);
    in_vsync = 1'b0; step(4);
  endtask

  task automatic set_red_window();
    r_min = 5'd31; r_max = 5'd31; g_min = 6'd0; g_max = 6'd0; b_min = 5'd0; b_max = 5'd0;
  endtask

  task automatic check_box(input string nm, input int x0, input int x1,
                           input int y0, input int y1, input int cnt, input bit v);
    chk({nm, "_cnt"}, 32'(hit_count), 32'(cnt));
    chk({nm, "_valid"}, 32'(bbox_valid), 32'(v));
    if (v) begin
      chk({nm, "_box"}, {bbox_x_min[7:0], bbox_x_max[7:0], bbox_y_min[7:0], bbox_y_max[7:0]},
          {8'(x0), 8'(x1), 8'(y0), 8'(y1)});
    end
  endtask

  int d0;

  initial begin
    rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0; in_data = 16'h0000;
    set_red_window();
    clear_frame();
    step(3);
    chk("reset_outputs", 32'({bbox_valid, frame_done, pixel_hit, hit_count}), 32'd0);
    rst_n = 1'b1; step(2);

    // two hits -> valid box (2,5,1,3)
    clear_frame(); frame_pix[1][2] = 16'hF800; frame_pix[3][5] = 16'hF800;
    d0 = done_cnt; drive_frame(1'b0);
    chk("frameA_done", 32'(done_cnt - d0), 32'd1);
    check_box("frameA", 2, 5, 1, 3, 2, 1'b1);

    // single hit -> invalid
    clear_frame(); frame_pix[2][4] = 16'hF800;
    d0 = done_cnt; drive_frame(1'b0);
    chk("frameB_done", 32'(done_cnt - d0), 32'd1);
    check_box("frameB", 0, 0, 0, 0, 1, 1'b0);

    // corner hits, vsync falls on the last pixel
    clear_frame(); frame_pix[0][0] = 16'hF800; frame_pix[3][7] = 16'hF800;
    d0 = done_cnt; drive_frame(1'b1);
    chk("frameC_done", 32'(done_cnt - d0), 32'd1);
    check_box("frameC", 0, 7, 0, 3, 2, 1'b1);

    // reset mid-frame: partial frame never published
    clear_frame(); frame_pix[1][2] = 16'hF800; frame_pix[3][5] = 16'hF800;
    d0 = done_cnt;
    in_vsync = 1'b0; step(2); in_vsync = 1'b1; step(2);
    drive_line(0, 1'b0); drive_line(1, 1'b0);
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    drive_line(2, 1'b0); drive_line(3, 1'b0);
    in_vsync = 1'b0; step(4);
    chk("partial_no_done", 32'(done_cnt - d0), 32'd0);
    check_box("partial", 0, 0, 0, 0, 0, 1'b0);
    drive_frame(1'b0);
    chk("after_rst_done", 32'(done_cnt - d0), 32'd1);
    check_box("after_rst", 2, 5, 1, 3, 2, 1'b1);

    // inverted R window matches nothing
    r_min = 5'd10; r_max = 5'd5;
    d0 = done_cnt; drive_frame(1'b0);
    chk("inv_win_done", 32'(done_cnt - d0), 32'd1);
    check_box("inv_win", 0, 0, 0, 0, 0, 1'b0);

    // establish box (2,5,1,3), then inspect the next frame's pass-through
    set_red_window();
    drive_frame(1'b0);
    check_box("prebox", 2, 5, 1, 3, 2, 1'b1);
    clear_frame();
    drive_frame(1'b0);
`ifdef COLOR_BBOX_OVERLAY_EN
    chk("ovl_2_2", 32'(obs[2][2]), 32'h0000F800);
    chk("ovl_4_1", 32'(obs[1][4]), 32'h0000F800);
`else
    chk("ovl_2_2", 32'(obs[2][2]), 32'h000007E0);
    chk("ovl_4_1", 32'(obs[1][4]), 32'h000007E0);
`endif
    chk("ovl_3_2", 32'(obs[2][3]), 32'h000007E0);
    check_box("blank", 0, 0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
